// File: rtl/bitcoin_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bitcoin_pkg                                                          |
// | Shared types and sizes for the miner host link: FSM state enum,      |
// | header/hash geometry and counter widths.                             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package bitcoin_pkg;

  localparam int HDR_BITS   = 640;
  localparam int HDR_WORDS  = 40;   // 16-bit words per header
  localparam int HASH_BITS  = 256;
  localparam int HASH_BYTES = 32;
  localparam int CNT_W      = 6;    // word / byte counters
  localparam int CYC_W      = 32;   // cycles output
  localparam int TMO_W      = 32;   // timeout counter

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_RQ      = 3'd1,
    W_LOW     = 3'd2,
    WAIT_DONE = 3'd3,
    R_RQ      = 3'd4,
    R_LOW     = 3'd5,
    FIN       = 3'd6,
    ERR       = 3'd7
  } state_t;

  // States in which the link waits on the miner; these are the busy
  // states and the only ones subject to the timeout.
  function automatic logic is_wait(input state_t s);
    return (s == W_RQ) || (s == W_LOW) || (s == WAIT_DONE) ||
           (s == R_RQ) || (s == R_LOW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitcoin_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bitcoin_sync                                                         |
// | N-stage single-bit synchronizer for asynchronous miner strobes.      |
// | Ports: clk, rst (sync, active high), d (async in), q (synced out).   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module bitcoin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/bitcoin_host_link.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bitcoin_host_link                                                    |
// | Host side of the miner link: streams a 640-bit header to the miner   |
// | as 40 rq-paced 16-bit words, waits for done, then collects 32 hash   |
// | bytes addressed by chip_addr with an ack handshake on chip_ui_o[7].  |
// | Ports: start/header in; busy, hash_valid, hash, err, cycles out;     |
// |        chip_ui_o/chip_uio_o/chip_uio_oe to miner;                    |
// |        chip_uio_i/chip_addr/chip_done/chip_rq from miner.            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module bitcoin_host_link
  import bitcoin_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [HDR_BITS-1:0]  header,
  output logic                 busy,
  output logic                 hash_valid,
  output logic [HASH_BITS-1:0] hash,
  output logic                 err,
  output logic [CYC_W-1:0]     cycles,
  output logic [7:0]           chip_ui_o,
  output logic [7:0]           chip_uio_o,
  output logic                 chip_uio_oe,
  input  logic [7:0]           chip_uio_i,
  input  logic [5:0]           chip_addr,
  input  logic                 chip_done,
  input  logic                 chip_rq
);

  localparam logic [TMO_W-1:0] c_tmo_last  = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_word_last = CNT_W'(HDR_WORDS - 1);
  localparam logic [CNT_W-1:0] c_byte_last = CNT_W'(HASH_BYTES - 1);
  localparam logic [5:0]       c_addr_lim  = 6'(HASH_BYTES);

  state_t               r_state, w_next;
  logic [HDR_BITS-1:0]  r_hdr;       // shifted left one word per rq pulse
  logic [CNT_W-1:0]     r_word, r_byte;
  logic [TMO_W-1:0]     r_tmo;
  logic [HASH_BITS-1:0] r_hash;
  logic [CYC_W-1:0]     r_cycles;
  logic                 r_err;

  logic       w_rq, w_done;
  logic       w_accept, w_tmo_hit, w_word_done, w_byte_done, w_cap;
  logic [7:0] w_slot;

  bitcoin_sync #(.STAGES(SYNC_STAGES)) u_sync_rq (
    .clk(clk), .rst(rst), .d(chip_rq), .q(w_rq)
  );

  bitcoin_sync #(.STAGES(SYNC_STAGES)) u_sync_done (
    .clk(clk), .rst(rst), .d(chip_done), .q(w_done)
  );

  assign w_accept  = start && ((r_state == IDLE) || (r_state == ERR));
  assign w_tmo_hit = (r_tmo == c_tmo_last);
  // Byte at address a lives at bit 255-8a downwards, i.e. slot 31-a.
  assign w_slot    = {~chip_addr[4:0], 3'b000};

  always_comb begin
    w_next      = r_state;
    w_word_done = 1'b0;
    w_byte_done = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      IDLE, ERR: begin
        if (start) w_next = W_RQ;
      end
      W_RQ: begin
        if (w_rq)           w_next = W_LOW;
        else if (w_tmo_hit) w_next = ERR;
      end
      W_LOW: begin
        if (!w_rq) begin
          w_word_done = 1'b1;
          w_next      = (r_word == c_word_last) ? WAIT_DONE : W_RQ;
        end else if (w_tmo_hit) begin
          w_next = ERR;
        end
      end
      WAIT_DONE: begin
        if (w_done)         w_next = R_RQ;
        else if (w_tmo_hit) w_next = ERR;
      end
      R_RQ: begin
        if (w_rq) begin
          if (chip_addr >= c_addr_lim) begin
            w_next = ERR;
          end else begin
            w_cap  = 1'b1;
            w_next = R_LOW;
          end
        end else if (w_tmo_hit) begin
          w_next = ERR;
        end
      end
      R_LOW: begin
        if (!w_rq) begin
          w_byte_done = 1'b1;
          w_next      = (r_byte == c_byte_last) ? FIN : R_RQ;
        end else if (w_tmo_hit) begin
          w_next = ERR;
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_hdr    <= '0;
      r_word   <= '0;
      r_byte   <= '0;
      r_tmo    <= '0;
      r_hash   <= '0;
      r_cycles <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;

      // Counts cycles spent in the current wait state only.
      if ((w_next != r_state) || !is_wait(r_state)) r_tmo <= '0;
      else                                          r_tmo <= r_tmo + 1'b1;

      if (w_accept) begin
        r_hdr    <= header;
        r_word   <= '0;
        r_byte   <= '0;
        r_hash   <= '0;
        r_cycles <= '0;
        r_err    <= 1'b0;
      end else begin
        if (is_wait(r_state) && !(&r_cycles)) r_cycles <= r_cycles + 1'b1;
        if (w_word_done) begin
          r_hdr  <= {r_hdr[HDR_BITS-17:0], 16'h0000};
          r_word <= r_word + 1'b1;
        end
        if (w_cap)       r_hash[w_slot +: 8] <= chip_uio_i;
        if (w_byte_done) r_byte <= r_byte + 1'b1;
        if ((w_next == ERR) && (r_state != ERR)) r_err <= 1'b1;
      end
    end
  end

  // Miner-facing outputs decode from the state register so that ERR and
  // reset drive everything low on the following cycle.
  always_comb begin
    chip_ui_o   = 8'h00;
    chip_uio_o  = 8'h00;
    chip_uio_oe = 1'b0;
    case (r_state)
      W_RQ: chip_uio_oe = 1'b1;
      W_LOW: begin
        chip_uio_oe = 1'b1;
        chip_ui_o   = r_hdr[HDR_BITS-1 -: 8];
        chip_uio_o  = r_hdr[HDR_BITS-9 -: 8];
      end
      R_LOW:   chip_ui_o = 8'h80;   // ack
      default: ;
    endcase
  end

  assign busy       = is_wait(r_state);
  assign hash_valid = (r_state == FIN);
  assign hash       = r_hash;
  assign err        = r_err;
  assign cycles     = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_bitcoin_host_link.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bitcoin_host_link                                                 |
// | Directed/randomized bench with a behavioural miner model.            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_bitcoin_host_link;

  localparam logic [639:0] c_genesis = 640'h0100000000000000000000000000000000000000000000000000000000000000000000003ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a29ab5f49ffff001d1dac2b7c;
  localparam logic [255:0] c_hash_seq = 256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7b8b9babbbcbdbebf;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [639:0] header = '0;
  logic         busy, hash_valid, err, chip_uio_oe;
  logic [255:0] hash;
  logic [31:0]  cycles;
  logic [7:0]   chip_ui_o, chip_uio_o;
  logic [7:0]   chip_uio_i = 8'h00;
  logic [5:0]   chip_addr = 6'd0;
  logic         chip_done = 1'b0;
  logic         chip_rq = 1'b0;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           hv_cnt = 0;
  int           hv_cyc = 0;
  logic         hv_busy = 1'b0;
  logic [255:0] hv_hash = '0;
  int           start_cyc = 0;
  logic [15:0]  got_words[$];
  logic [7:0]   mdata[32];
  int           morder[32];

  bitcoin_host_link #(.SYNC_STAGES(2), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .start(start), .header(header),
    .busy(busy), .hash_valid(hash_valid), .hash(hash), .err(err),
    .cycles(cycles), .chip_ui_o(chip_ui_o), .chip_uio_o(chip_uio_o),
    .chip_uio_oe(chip_uio_oe), .chip_uio_i(chip_uio_i),
    .chip_addr(chip_addr), .chip_done(chip_done), .chip_rq(chip_rq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hash_valid) begin
      hv_cnt  = hv_cnt + 1;
      hv_cyc  = cyc;
      hv_busy = busy;
      hv_hash = hash;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 256'(busy), 256'(1'b0));
    chk({tag, "_hv"},   256'(hash_valid), 256'(1'b0));
    chk({tag, "_ui"},   256'(chip_ui_o), 256'(8'h00));
    chk({tag, "_uio"},  256'(chip_uio_o), 256'(8'h00));
    chk({tag, "_oe"},   256'(chip_uio_oe), 256'(1'b0));
  endtask

  function automatic logic [639:0] rand_hdr();
    logic [639:0] h = '0;
    for (int j = 0; j < 20; j++) h = {h[607:0], 32'($urandom())};
    return h;
  endfunction

  // Hash the miner has delivered after the first n bytes of morder.
  function automatic logic [255:0] exp_hash(input int n);
    logic [255:0] h = '0;
    for (int k = 0; k < n; k++)
      h = h | (256'(mdata[morder[k]]) << (8 * (31 - morder[k])));
    return h;
  endfunction

  task automatic set_seq_data(input bit reverse);
    for (int a = 0; a < 32; a++) begin
      mdata[a]  = 8'(8'ha0 + a);
      morder[a] = reverse ? 31 - a : a;
    end
  endtask

  task automatic set_rand_data();
    int j, t;
    for (int a = 0; a < 32; a++) begin
      mdata[a]  = 8'($urandom());
      morder[a] = a;
    end
    for (int a = 31; a > 0; a--) begin
      j = $urandom_range(0, a);
      t = morder[a]; morder[a] = morder[j]; morder[j] = t;
    end
  endtask

  task automatic do_start(input logic [639:0] h);
    header = h;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start_cyc = cyc;
    chk("start_busy",   256'(busy), 256'(1'b1));
    chk("start_err",    256'(err), 256'(1'b0));
    chk("start_cycles", 256'(cycles), 256'(0));
  endtask

  // Miner model, write phase: raise rq, give the host time to present a
  // word, take it, drop rq. Optional stall (rq left high) or stray start.
  task automatic miner_write(input int stall_at, input int dup_at);
    got_words.delete();
    for (int i = 0; i < 40; i++) begin
      if (i == dup_at) begin
        header = rand_hdr();
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
      end
      chip_rq = 1'b1;
      if (i == stall_at) return;
      repeat ($urandom_range(5, 9)) @(negedge clk);
      chk("word_oe", 256'(chip_uio_oe), 256'(1'b1));
      got_words.push_back({chip_ui_o, chip_uio_o});
      chip_rq = 1'b0;
      repeat ($urandom_range(5, 9)) @(negedge clk);
    end
  endtask

  task automatic chk_words(input logic [639:0] h, input int n);
    chk("word_count", 256'(got_words.size()), 256'(n));
    if (got_words.size() == n)
      for (int i = 0; i < n; i++)
        chk("word", 256'(got_words[i]), 256'(16'(h >> (16 * (39 - i)))));
  endtask

  // Miner model, read phase: present addr/data, raise rq, wait for ack,
  // drop rq, wait for ack release. Optional bad address or reset at byte k.
  task automatic miner_read(input int bad_at, input int rst_at);
    int n;
    chip_done = 1'b1;
    for (int k = 0; k < 32; k++) begin
      chip_addr  = (k == bad_at) ? 6'(32 + $urandom_range(0, 31)) : 6'(morder[k]);
      chip_uio_i = mdata[morder[k]];
      chip_rq    = 1'b1;
      if (k == bad_at) begin
        repeat (8) @(negedge clk);
        return;
      end
      if (k == rst_at) begin
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        return;
      end
      n = 0;
      while (!chip_ui_o[7] && n < 30) begin @(negedge clk); n++; end
      chk("ack_rise", 256'(chip_ui_o[7]), 256'(1'b1));
      chip_rq = 1'b0;
      n = 0;
      while (chip_ui_o[7] && n < 30) begin @(negedge clk); n++; end
      chk("ack_fall", 256'(chip_ui_o[7]), 256'(1'b0));
    end
  endtask

  task automatic cleanup();
    chip_rq   = 1'b0;
    chip_done = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_txn(input logic [639:0] h, input int dup_at, input logic [255:0] exp_h);
    int hv0;
    hv0 = hv_cnt;
    do_start(h);
    miner_write(-1, dup_at);
    chk_words(h, 40);
    chk("wd_ui", 256'(chip_ui_o), 256'(8'h00));
    chk("wd_oe", 256'(chip_uio_oe), 256'(1'b0));
    chk("wd_busy", 256'(busy), 256'(1'b1));
    miner_read(-1, -1);
    repeat (2) @(negedge clk);
    chk("hv_pulses", 256'(hv_cnt - hv0), 256'(1));
    chk("hv_hash", hv_hash, exp_h);
    chk("hv_busy", 256'(hv_busy), 256'(1'b0));
    chk("cycles", 256'(cycles), 256'(hv_cyc - start_cyc));
    chk("hash_held", hash, exp_h);
    chk("err_clear", 256'(err), 256'(1'b0));
    chk_quiet("post");
    cleanup();
  endtask

  initial begin
    logic [639:0] h;
    int           k;
    int           hv0;

    repeat (4) @(negedge clk);
    chk_quiet("rst");
    chk("rst_err", 256'(err), 256'(1'b0));
    chk("rst_hash", hash, 256'(0));
    chk("rst_cycles", 256'(cycles), 256'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Genesis header, ascending addresses, known byte pattern.
    set_seq_data(1'b0);
    run_txn(c_genesis, -1, c_hash_seq);
    chk("genesis_first", 256'(got_words[0]), 256'(16'h0100));
    chk("genesis_last", 256'(got_words[39]), 256'(16'h2b7c));

    // Same bytes delivered in reverse address order.
    set_seq_data(1'b1);
    run_txn(c_genesis, -1, c_hash_seq);

    // Random header and data, shuffled addresses, stray start mid-write.
    h = rand_hdr();
    set_rand_data();
    run_txn(h, 7, exp_hash(32));

    // Out-of-range address partway through the read.
    h = rand_hdr();
    set_rand_data();
    k = $urandom_range(3, 28);
    hv0 = hv_cnt;
    do_start(h);
    miner_write(-1, -1);
    chk_words(h, 40);
    miner_read(k, -1);
    chk("bad_err", 256'(err), 256'(1'b1));
    chk("bad_hash", hash, exp_hash(k));
    chk("bad_hv", 256'(hv_cnt - hv0), 256'(0));
    chk_quiet("bad");
    cleanup();

    // Stall rq high at word 5: timeout after 100 cycles in W_LOW.
    h = rand_hdr();
    do_start(h);
    miner_write(5, -1);
    repeat (100) @(negedge clk);
    chk("tmo_early", 256'(err), 256'(1'b0));
    repeat (5) @(negedge clk);
    chk("tmo_err", 256'(err), 256'(1'b1));
    chk_quiet("tmo");
    chk_words(h, 5);
    cleanup();

    // Recovery from ERR through a normal transaction.
    h = rand_hdr();
    set_rand_data();
    run_txn(h, -1, exp_hash(32));

    // Reset in the middle of read byte 10.
    h = rand_hdr();
    set_rand_data();
    hv0 = hv_cnt;
    do_start(h);
    miner_write(-1, -1);
    miner_read(-1, 10);
    chk_quiet("mid_rst");
    chk("mid_rst_err", 256'(err), 256'(1'b0));
    chk("mid_rst_hash", hash, 256'(0));
    chk("mid_rst_cycles", 256'(cycles), 256'(0));
    rst = 1'b0;
    cleanup();
    chk("mid_rst_hv", 256'(hv_cnt - hv0), 256'(0));

    h = rand_hdr();
    set_rand_data();
    run_txn(h, -1, exp_hash(32));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
